// File: rtl/psum_gbf_wrapper.sv
// Double-buffered partial-sum global buffer: two identical banks that swap
// fill/drain roles on psum_gbf_w_num (ping-pong between PE output and drain path).

module psum_gbf_bank #(
    parameter int DATA_BITWIDTH = 512,
    parameter int ADDR_BITWIDTH = 5,
    parameter int DEPTH         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [ADDR_BITWIDTH-1:0] w_addr,
    input  logic [DATA_BITWIDTH-1:0] w_data,
    input  logic                     r_en,
    input  logic [ADDR_BITWIDTH-1:0] r_addr,
    output logic [DATA_BITWIDTH-1:0] r_data,
    output logic                     r_valid
);

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    // Contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    // Registered read port; the read samples the array before a same-edge
    // write lands, giving read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_en;
            if (r_en) begin
                r_data <= mem[r_addr];
            end
        end
    end

endmodule

module psum_gbf_wrapper #(
    parameter int ROW                    = 16,
    parameter int COL                    = 16,
    parameter int OUT_BITWIDTH           = 16,
    parameter int PSUM_GBF_DATA_BITWIDTH = 512,
    parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
    parameter int PSUM_GBF_DEPTH         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] out_data,
    input  logic                              psum_gbf_w_en,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr,
    input  logic                              psum_gbf_w_num,
    input  logic                              psum_gbf_r_en,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_r_addr,
    input  logic                              psum_gbf_w_en_for_init,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0] psum_gbf_w_addr_for_init,
    output logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data1b_out,
    output logic [PSUM_GBF_DATA_BITWIDTH-1:0] r_data2b_out,
    output logic                              r_en1b_out,
    output logic                              r_en2b_out
);

    localparam int DW = PSUM_GBF_DATA_BITWIDTH;
    localparam int AW = PSUM_GBF_ADDR_BITWIDTH;

    generate
        if ((DW % OUT_BITWIDTH) != 0 || (1 << AW) != PSUM_GBF_DEPTH || ROW < 1 || COL < 1) begin : g_bad_params
            $error("psum_gbf_wrapper: inconsistent parameters");
        end
    endgenerate

    // Bank 1b fills when w_num=0 and drains when w_num=1; bank 2b is the mirror.
    logic          fill_1b, fill_2b;
    logic          init_1b, init_2b;
    logic          we_1b, we_2b;
    logic          re_1b, re_2b;
    logic [AW-1:0] waddr_1b, waddr_2b;
    logic [DW-1:0] wdata_1b, wdata_2b;

    always_comb begin
        fill_1b  = psum_gbf_w_en & ~psum_gbf_w_num;
        fill_2b  = psum_gbf_w_en &  psum_gbf_w_num;
        init_1b  = psum_gbf_w_en_for_init &  psum_gbf_w_num;
        init_2b  = psum_gbf_w_en_for_init & ~psum_gbf_w_num;

        // A bank is never fill and drain at once, so the write-port mux
        // never has two sources competing.
        we_1b    = ~rst & (fill_1b | init_1b);
        we_2b    = ~rst & (fill_2b | init_2b);
        waddr_1b = fill_1b ? psum_gbf_w_addr : psum_gbf_w_addr_for_init;
        waddr_2b = fill_2b ? psum_gbf_w_addr : psum_gbf_w_addr_for_init;
        wdata_1b = fill_1b ? out_data : '0;
        wdata_2b = fill_2b ? out_data : '0;

        re_1b    = psum_gbf_r_en &  psum_gbf_w_num;
        re_2b    = psum_gbf_r_en & ~psum_gbf_w_num;
    end

    psum_gbf_bank #(
        .DATA_BITWIDTH (DW),
        .ADDR_BITWIDTH (AW),
        .DEPTH         (PSUM_GBF_DEPTH)
    ) u_bank_1b (
        .clk     (clk),
        .rst     (rst),
        .w_en    (we_1b),
        .w_addr  (waddr_1b),
        .w_data  (wdata_1b),
        .r_en    (re_1b),
        .r_addr  (psum_gbf_r_addr),
        .r_data  (r_data1b_out),
        .r_valid (r_en1b_out)
    );

    psum_gbf_bank #(
        .DATA_BITWIDTH (DW),
        .ADDR_BITWIDTH (AW),
        .DEPTH         (PSUM_GBF_DEPTH)
    ) u_bank_2b (
        .clk     (clk),
        .rst     (rst),
        .w_en    (we_2b),
        .w_addr  (waddr_2b),
        .w_data  (wdata_2b),
        .r_en    (re_2b),
        .r_addr  (psum_gbf_r_addr),
        .r_data  (r_data2b_out),
        .r_valid (r_en2b_out)
    );

endmodule

// File: tb/tb_psum_gbf_wrapper.sv
// Bench for psum_gbf_wrapper: table of request cycles plus hand sequences,
// read data checked against an expected queue per bank.

module tb_psum_gbf_wrapper;

    localparam int DW    = 512;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam logic [31:0] BASE_A = 32'hA000_0000;
    localparam logic [31:0] BASE_B = 32'hB000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] out_data;
    logic          psum_gbf_w_en;
    logic [AW-1:0] psum_gbf_w_addr;
    logic          psum_gbf_w_num;
    logic          psum_gbf_r_en;
    logic [AW-1:0] psum_gbf_r_addr;
    logic          psum_gbf_w_en_for_init;
    logic [AW-1:0] psum_gbf_w_addr_for_init;
    logic [DW-1:0] r_data1b_out;
    logic [DW-1:0] r_data2b_out;
    logic          r_en1b_out;
    logic          r_en2b_out;

    always #5 clk = ~clk;

    psum_gbf_wrapper #(
        .ROW                    (16),
        .COL                    (16),
        .OUT_BITWIDTH           (16),
        .PSUM_GBF_DATA_BITWIDTH (DW),
        .PSUM_GBF_ADDR_BITWIDTH (AW),
        .PSUM_GBF_DEPTH         (DEPTH)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .out_data                 (out_data),
        .psum_gbf_w_en            (psum_gbf_w_en),
        .psum_gbf_w_addr          (psum_gbf_w_addr),
        .psum_gbf_w_num           (psum_gbf_w_num),
        .psum_gbf_r_en            (psum_gbf_r_en),
        .psum_gbf_r_addr          (psum_gbf_r_addr),
        .psum_gbf_w_en_for_init   (psum_gbf_w_en_for_init),
        .psum_gbf_w_addr_for_init (psum_gbf_w_addr_for_init),
        .r_data1b_out             (r_data1b_out),
        .r_data2b_out             (r_data2b_out),
        .r_en1b_out               (r_en1b_out),
        .r_en2b_out               (r_en2b_out)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] m1 [DEPTH];
    logic [DW-1:0] m2 [DEPTH];
    logic [DW-1:0] exp_q1 [$];
    logic [DW-1:0] exp_q2 [$];
    logic          pend1, pend2;
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last2 = '0;

    typedef struct {
        logic          rst;
        logic          w_en;
        logic [AW-1:0] w_addr;
        logic          w_num;
        logic          r_en;
        logic [AW-1:0] r_addr;
        logic          init;
        logic [AW-1:0] init_addr;
        logic [1:0]    dsel;
        logic          ev1;
        logic          ev2;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [DW-1:0] pat(input logic [31:0] base, input int a);
        logic [31:0] w;
        w = base + 32'(a);
        return {16{w}};
    endfunction

    function automatic vec_t mk(input logic r, we, input int wa, input logic wn, re,
                                input int ra, input logic in, input int ia,
                                input int ds, input logic e1, e2);
        vec_t v;
        v.rst = r; v.w_en = we; v.w_addr = AW'(wa); v.w_num = wn;
        v.r_en = re; v.r_addr = AW'(ra); v.init = in; v.init_addr = AW'(ia);
        v.dsel = 2'(ds); v.ev1 = e1; v.ev2 = e2;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: pops an expected word when a valid pulse is due,
    // otherwise requires the data outputs to hold.
    task automatic check_outputs(input logic was_rst);
        if (was_rst) begin
            last1 = '0;
            last2 = '0;
        end
        check_bit("r_en1b_out", r_en1b_out, pend1);
        check_bit("r_en2b_out", r_en2b_out, pend2);
        if (pend1 && exp_q1.size() > 0) last1 = exp_q1.pop_front();
        if (pend2 && exp_q2.size() > 0) last2 = exp_q2.pop_front();
        check_word("r_data1b_out", r_data1b_out, last1);
        check_word("r_data2b_out", r_data2b_out, last2);
    endtask

    // Driver side: applies one request cycle and pushes the expected read
    // result (taken before this cycle's writes, i.e. read-before-write).
    task automatic drive_cycle(input logic c_rst, c_w_en, input logic [AW-1:0] c_w_addr,
                               input logic c_w_num, c_r_en, input logic [AW-1:0] c_r_addr,
                               input logic c_init, input logic [AW-1:0] c_init_addr,
                               input logic [DW-1:0] c_data);
        rst                      = c_rst;
        psum_gbf_w_en            = c_w_en;
        psum_gbf_w_addr          = c_w_addr;
        psum_gbf_w_num           = c_w_num;
        psum_gbf_r_en            = c_r_en;
        psum_gbf_r_addr          = c_r_addr;
        psum_gbf_w_en_for_init   = c_init;
        psum_gbf_w_addr_for_init = c_init_addr;
        out_data                 = c_data;
        pend1 = 1'b0;
        pend2 = 1'b0;
        if (!c_rst) begin
            if (c_r_en) begin
                if (c_w_num) begin exp_q1.push_back(m1[c_r_addr]); pend1 = 1'b1; end
                else         begin exp_q2.push_back(m2[c_r_addr]); pend2 = 1'b1; end
            end
            if (c_w_en) begin
                if (c_w_num) m2[c_w_addr] = c_data;
                else         m1[c_w_addr] = c_data;
            end
            if (c_init) begin
                if (c_w_num) m1[c_init_addr] = '0;
                else         m2[c_init_addr] = '0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(c_rst);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int a;

        rst = 1'b1; out_data = '0; psum_gbf_w_en = 1'b0; psum_gbf_w_addr = '0;
        psum_gbf_w_num = 1'b0; psum_gbf_r_en = 1'b0; psum_gbf_r_addr = '0;
        psum_gbf_w_en_for_init = 1'b0; psum_gbf_w_addr_for_init = '0;

        // Reset for two cycles, then quiet cycles with no read pulses.
        repeat (2) drive_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        repeat (2) idle();

        // Fill bank 1b with pattern A, then drain-read address 5.
        for (int i = 0; i < DEPTH; i++)
            drive_cycle(1'b0, 1'b1, AW'(i), 1'b0, 1'b0, '0, 1'b0, '0, pat(BASE_A, i));
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(5), 1'b0, '0, '0);
        check_word("fill_read_a5", r_data1b_out, pat(BASE_A, 5));
        check_bit("fill_read_no_2b", r_en2b_out, 1'b0);
        idle();
        check_word("fill_read_hold", r_data1b_out, pat(BASE_A, 5));

        // Table: ping-pong, swap, init, post-init reads of both banks.
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 1, i, 1, 1, i, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, i, 0, 0, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 1, 1, i, 0, 0, 0, 1, 0));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 0, 0, 1, i, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[k]) begin
            case (vecs[k].dsel)
                2'd1:    d = pat(BASE_A, int'(vecs[k].w_addr));
                2'd2:    d = pat(BASE_B, int'(vecs[k].w_addr));
                default: d = '0;
            endcase
            drive_cycle(vecs[k].rst, vecs[k].w_en, vecs[k].w_addr, vecs[k].w_num,
                        vecs[k].r_en, vecs[k].r_addr, vecs[k].init, vecs[k].init_addr, d);
            check_bit("tbl_en1b", r_en1b_out, vecs[k].ev1);
            check_bit("tbl_en2b", r_en2b_out, vecs[k].ev2);
        end

        // Spot constants after the table: last reads were 1b@5 and 2b@5.
        check_word("tbl_last_1b", r_data1b_out, pat(BASE_A, 5));
        check_word("tbl_last_2b", r_data2b_out, pat(BASE_B, 5));

        // Read and init on the same address in the same cycle.
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(7), 1'b1, AW'(7), '0);
        check_word("collide_old", r_data1b_out, pat(BASE_A, 7));
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(7), 1'b0, '0, '0);
        check_word("collide_zero", r_data1b_out, '0);

        // Reset while a read is issued: no pulse, outputs cleared, memory kept.
        drive_cycle(1'b1, 1'b0, '0, 1'b1, 1'b1, AW'(10), 1'b0, '0, '0);
        check_bit("rst_mid_en1b", r_en1b_out, 1'b0);
        check_word("rst_mid_d1b", r_data1b_out, '0);
        check_word("rst_mid_d2b", r_data2b_out, '0);
        idle();
        check_bit("rst_after_en1b", r_en1b_out, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(10), 1'b0, '0, '0);
        check_word("rst_retain_a10", r_data1b_out, pat(BASE_A, 10));

        // Random drain reads of untouched pattern-A words in bank 1b.
        repeat (10) begin
            a = $urandom_range(8, DEPTH - 1);
            drive_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, AW'(a), 1'b0, '0, '0);
            check_word("rand_read_1b", r_data1b_out, pat(BASE_A, a));
        end
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
